// File: rtl/hpm_event_counters_if.sv
// CSR access bus between the privileged CSR unit (master) and the HPM counter bank (slave).
interface hpm_event_counters_if #(
  parameter int unsigned XLEN = 64
);
  logic            CSRMWriteM;
  logic [11:0]     CSRAdrM;
  logic [XLEN-1:0] CSRWriteValM;
  logic [XLEN-1:0] CSRReadValM;
  logic            IllegalAccessM;

  modport master (
    output CSRMWriteM, CSRAdrM, CSRWriteValM,
    input  CSRReadValM, IllegalAccessM
  );

  modport slave (
    input  CSRMWriteM, CSRAdrM, CSRWriteValM,
    output CSRReadValM, IllegalAccessM
  );
endinterface

// File: rtl/hpm_event_counters.sv
// Programmable HPM counter bank (mhpmcounter/mhpmevent 3..N, scountovf) with overflow flags,
// per-privilege inhibit and local-counter-overflow interrupt request.
module hpm_event_counters #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned NUM_HPM    = 8,
  parameter int unsigned NUM_EVENTS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] Events,
  input  logic [1:0]            PrivilegeModeW,
  input  logic [31:0]           MCOUNTINHIBIT,
  hpm_event_counters_if.slave   csr,
  output logic                  LCOFIReqM,
  output logic [31:0]           ScountovfM
);

  localparam int unsigned FIRST = 3;
  localparam int unsigned LAST  = FIRST + NUM_HPM - 1;

  logic [63:0]      counter [FIRST:LAST];
  logic [7:0]       sel     [FIRST:LAST];
  logic [LAST:FIRST] of, mInh, sInh, uInh;

  logic [11:0] adr;
  logic [63:0] wd64;
  logic [63:0] rd64;
  logic [4:0]  idx;
  logic        isCnt, isCntH, isEvt, isEvtH, isOvf, hiHalf, idxImpl, illegal, wrEn;
  logic        hit, modeInh, wrOf;
  logic [LAST:FIRST] en, wrLo, wrHi, wrEv, wrEvH, setOf;
  logic        unusedBits;

  assign adr  = csr.CSRAdrM;
  assign wd64 = 64'(csr.CSRWriteValM);

  // Address decode; idx is the counter number for any of the four per-counter ranges
  always_comb begin
    isCnt  = (adr >= 12'hB03) && (adr <= 12'hB1F);
    isCntH = (adr >= 12'hB83) && (adr <= 12'hB9F);
    isEvt  = (adr >= 12'h326) && (adr <= 12'h342);
    isEvtH = (adr >= 12'h726) && (adr <= 12'h742);
    isOvf  = (adr == 12'hDA0);
    idx    = '0;
    if (isCnt)       idx = 5'(adr - 12'hB00);
    else if (isCntH) idx = 5'(adr - 12'hB80);
    else if (isEvt)  idx = 5'(adr - 12'h323);
    else if (isEvtH) idx = 5'(adr - 12'h723);
    hiHalf  = isCntH | isEvtH;
    idxImpl = 32'(idx) <= LAST;
    illegal = ((isCnt | isEvt | hiHalf) & ~idxImpl) | (hiHalf & (XLEN == 64)) |
              (isOvf & csr.CSRMWriteM);
    wrEn    = csr.CSRMWriteM & ~illegal;
  end

  // Per-counter enables, write strobes and hardware overflow set
  always_comb begin
    en = '0; wrLo = '0; wrHi = '0; wrEv = '0; wrEvH = '0; setOf = '0;
    hit = 1'b0; modeInh = 1'b0; wrOf = 1'b0;
    for (int unsigned i = FIRST; i <= LAST; i++) begin
      hit = 1'b0;
      for (int unsigned k = 0; k < NUM_EVENTS; k++)
        if (sel[i] == 8'(k + 1)) hit = Events[k];
      case (PrivilegeModeW)
        2'b11:   modeInh = mInh[i];
        2'b01:   modeInh = sInh[i];
        2'b00:   modeInh = uInh[i];
        default: modeInh = 1'b0;
      endcase
      en[i]    = hit & ~MCOUNTINHIBIT[i] & ~modeInh;
      wrLo[i]  = wrEn & isCnt  & (idx == 5'(i));
      wrHi[i]  = wrEn & isCntH & (idx == 5'(i));
      wrEv[i]  = wrEn & isEvt  & (idx == 5'(i));
      wrEvH[i] = wrEn & isEvtH & (idx == 5'(i));
      wrOf     = (XLEN == 64) ? wrEv[i] : wrEvH[i];
      setOf[i] = en[i] & ~wrLo[i] & ~wrHi[i] & (&counter[i]) & ~wrOf;
    end
  end

  assign LCOFIReqM = ~reset & (|(setOf & ~of));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = FIRST; i <= LAST; i++) begin
        counter[i] <= '0;
        sel[i]     <= '0;
      end
      of   <= '0;
      mInh <= '0;
      sInh <= '0;
      uInh <= '0;
    end else begin
      for (int unsigned i = FIRST; i <= LAST; i++) begin
        // A software write to either half suppresses the increment of the whole counter
        if (en[i] & ~wrLo[i] & ~wrHi[i]) counter[i] <= counter[i] + 64'd1;
        if (wrLo[i]) begin
          if (XLEN == 64) counter[i] <= wd64;
          else            counter[i][31:0] <= wd64[31:0];
        end
        if (wrHi[i]) counter[i][63:32] <= wd64[31:0];
        if (setOf[i]) of[i] <= 1'b1;
        if (wrEv[i]) begin
          sel[i] <= wd64[7:0];
          if (XLEN == 64) {of[i], mInh[i], sInh[i], uInh[i]} <= wd64[63:60];
        end
        if (wrEvH[i]) {of[i], mInh[i], sInh[i], uInh[i]} <= wd64[31:28];
      end
    end
  end

  always_comb begin
    ScountovfM = '0;
    for (int unsigned i = FIRST; i <= LAST; i++) ScountovfM[i] = of[i];
  end

  // Read mux works on the 64-bit logical view; truncation yields the XLEN=32 low halves
  always_comb begin
    rd64 = '0;
    if (!illegal) begin
      for (int unsigned i = FIRST; i <= LAST; i++) begin
        if (idx == 5'(i)) begin
          if (isCnt)       rd64 = counter[i];
          else if (isCntH) rd64 = {32'b0, counter[i][63:32]};
          else if (isEvt)  rd64 = {of[i], mInh[i], sInh[i], uInh[i], 52'b0, sel[i]};
          else if (isEvtH) rd64 = {32'b0, of[i], mInh[i], sInh[i], uInh[i], 28'b0};
        end
      end
      if (isOvf) rd64 = {32'b0, ScountovfM};
    end
    csr.CSRReadValM    = XLEN'(rd64);
    csr.IllegalAccessM = illegal;
  end

  assign unusedBits = ^{MCOUNTINHIBIT, wd64};

endmodule

// File: tb/tb_hpm_event_counters.sv
// Directed bench for hpm_event_counters: an XLEN=64/NUM_HPM=8 bank and an XLEN=32/NUM_HPM=4 bank.
module tb_hpm_event_counters;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ev64, ev32, inh;
  logic [1:0]  mode;
  logic        lcofi64, lcofi32;
  logic [31:0] ovf64, ovf32;
  logic [63:0] v;
  logic        il;
  int          nChecks = 0;
  int          nFails  = 0;

  hpm_event_counters_if #(.XLEN(64)) b64 ();
  hpm_event_counters_if #(.XLEN(32)) b32 ();

  hpm_event_counters #(.XLEN(64), .NUM_HPM(8), .NUM_EVENTS(32)) dut64 (
    .clk(clk), .reset(reset), .Events(ev64), .PrivilegeModeW(mode), .MCOUNTINHIBIT(inh),
    .csr(b64), .LCOFIReqM(lcofi64), .ScountovfM(ovf64));

  hpm_event_counters #(.XLEN(32), .NUM_HPM(4), .NUM_EVENTS(32)) dut32 (
    .clk(clk), .reset(reset), .Events(ev32), .PrivilegeModeW(mode), .MCOUNTINHIBIT(inh),
    .csr(b32), .LCOFIReqM(lcofi32), .ScountovfM(ovf32));

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr64(input logic [11:0] a, input logic [63:0] d);
    b64.CSRAdrM = a; b64.CSRWriteValM = d; b64.CSRMWriteM = 1'b1;
    tick();
    b64.CSRMWriteM = 1'b0;
  endtask

  task automatic wr32(input logic [11:0] a, input logic [31:0] d);
    b32.CSRAdrM = a; b32.CSRWriteValM = d; b32.CSRMWriteM = 1'b1;
    tick();
    b32.CSRMWriteM = 1'b0;
  endtask

  task automatic rd64(input logic [11:0] a, output logic [63:0] val, output logic ill);
    b64.CSRAdrM = a;
    #1;
    val = b64.CSRReadValM;
    ill = b64.IllegalAccessM;
  endtask

  task automatic rd32(input logic [11:0] a, output logic [63:0] val, output logic ill);
    b32.CSRAdrM = a;
    #1;
    val = 64'(b32.CSRReadValM);
    ill = b32.IllegalAccessM;
  endtask

  initial begin
    reset = 1'b1; ev64 = '0; ev32 = '0; inh = '0; mode = 2'b11;
    b64.CSRMWriteM = 1'b0; b64.CSRAdrM = '0; b64.CSRWriteValM = '0;
    b32.CSRMWriteM = 1'b0; b32.CSRAdrM = '0; b32.CSRWriteValM = '0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    rd64(12'hB03, v, il);
    checkVal("rst_cnt3", v, 64'd0);
    checkVal("rst_ill", 64'(il), 64'd0);
    checkVal("rst_ovf", 64'(ovf64), 64'd0);
    checkVal("rst_lcofi", 64'(lcofi64), 64'd0);
    rd64(12'h326, v, il);
    checkVal("rst_evt3", v, 64'd0);

    // Basic counting and MCOUNTINHIBIT
    wr64(12'h326, 64'd1);
    ev64 = 32'h1; repeat (5) tick(); ev64 = '0;
    rd64(12'hB03, v, il);
    checkVal("t1_count5", v, 64'd5);
    inh = 32'h8; ev64 = 32'h1; repeat (3) tick(); ev64 = '0; inh = '0;
    rd64(12'hB03, v, il);
    checkVal("t1_inhibit", v, 64'd5);
    rd64(12'h326, v, il);
    checkVal("t1_evt3", v, 64'd1);

    // Overflow with one LCOFI pulse
    wr64(12'hB04, 64'hFFFF_FFFF_FFFF_FFFE);
    wr64(12'h327, 64'd2);
    ev64 = 32'h2; #1;
    checkVal("t2_no_early_pulse", 64'(lcofi64), 64'd0);
    tick();
    checkVal("t2_pulse", 64'(lcofi64), 64'd1);
    tick();
    ev64 = '0; #1;
    checkVal("t2_pulse_once", 64'(lcofi64), 64'd0);
    rd64(12'hB04, v, il);
    checkVal("t2_wrap_zero", v, 64'd0);
    checkVal("t2_scountovf", 64'(ovf64), 64'h10);
    rd64(12'h327, v, il);
    checkVal("t2_evt4_of", v, 64'h8000_0000_0000_0002);

    // Wrap with OF already set is silent
    wr64(12'hB04, 64'hFFFF_FFFF_FFFF_FFFF);
    ev64 = 32'h2; #1;
    checkVal("t2_silent_wrap", 64'(lcofi64), 64'd0);
    tick(); ev64 = '0;
    rd64(12'hB04, v, il);
    checkVal("t2_wrapped", v, 64'd0);
    wr64(12'h327, 64'd2);
    checkVal("t2_of_cleared", 64'(ovf64), 64'd0);

    // Software event write in the overflow cycle wins
    wr64(12'hB04, 64'hFFFF_FFFF_FFFF_FFFF);
    ev64 = 32'h2;
    b64.CSRAdrM = 12'h327; b64.CSRWriteValM = 64'd2; b64.CSRMWriteM = 1'b1; #1;
    checkVal("t2_sw_wins_pulse", 64'(lcofi64), 64'd0);
    tick();
    b64.CSRMWriteM = 1'b0; ev64 = '0;
    checkVal("t2_sw_wins_of", 64'(ovf64), 64'd0);
    rd64(12'hB04, v, il);
    checkVal("t2_sw_wins_cnt", v, 64'd0);

    // Per-privilege inhibit on counter5
    wr64(12'h328, 64'h2000_0000_0000_0003);
    mode = 2'b01; ev64 = 32'h4; repeat (3) tick();
    mode = 2'b11; repeat (2) tick(); ev64 = '0;
    rd64(12'hB05, v, il);
    checkVal("t3_sinh", v, 64'd2);
    wr64(12'h328, 64'h1000_0000_0000_0003);
    mode = 2'b00; ev64 = 32'h4; repeat (3) tick(); ev64 = '0;
    rd64(12'hB05, v, il);
    checkVal("t3_uinh", v, 64'd2);
    mode = 2'b01; ev64 = 32'h4; tick(); ev64 = '0; mode = 2'b11;
    rd64(12'hB05, v, il);
    checkVal("t3_s_counts", v, 64'd3);

    // Counter write beats the same-cycle increment
    ev64 = 32'h1;
    b64.CSRAdrM = 12'hB03; b64.CSRWriteValM = 64'd100; b64.CSRMWriteM = 1'b1;
    tick();
    b64.CSRMWriteM = 1'b0;
    rd64(12'hB03, v, il);
    checkVal("t4_write_wins", v, 64'd100);
    tick(); ev64 = '0;
    rd64(12'hB03, v, il);
    checkVal("t4_then_inc", v, 64'd101);

    // Out-of-range select, unowned and illegal addresses
    wr64(12'h326, 64'h21);
    ev64 = 32'hFFFF_FFFF; repeat (2) tick(); ev64 = '0;
    rd64(12'hB03, v, il);
    checkVal("sel_oob_nocount", v, 64'd101);
    rd64(12'h326, v, il);
    checkVal("sel_oob_stored", v, 64'h21);
    rd64(12'h300, v, il);
    checkVal("unowned_val", v, 64'd0);
    checkVal("unowned_ill", 64'(il), 64'd0);
    rd64(12'hB83, v, il);
    checkVal("x64_h_ill", 64'(il), 64'd1);
    rd64(12'hB0B, v, il);
    checkVal("x64_unimpl_ill", 64'(il), 64'd1);
    rd64(12'hB0A, v, il);
    checkVal("x64_last_ok", 64'(il), 64'd0);

    // XLEN=32 halves and carry into the high half
    wr32(12'hB83, 32'd1);
    wr32(12'hB03, 32'hFFFF_FFFF);
    wr32(12'h326, 32'd1);
    ev32 = 32'h1; #1;
    checkVal("t5_no_pulse", 64'(lcofi32), 64'd0);
    tick(); ev32 = '0;
    rd32(12'hB03, v, il);
    checkVal("t5_lo", v, 64'd0);
    rd32(12'hB83, v, il);
    checkVal("t5_hi", v, 64'd2);
    checkVal("t5_ovf", 64'(ovf32), 64'd0);
    wr32(12'h726, 32'h4000_0000);
    ev32 = 32'h1; tick(); ev32 = '0;
    rd32(12'hB03, v, il);
    checkVal("t5_minh", v, 64'd0);
    rd32(12'h726, v, il);
    checkVal("t5_evth", v, 64'h4000_0000);
    rd32(12'h326, v, il);
    checkVal("t5_evt_lo", v, 64'd1);

    // NUM_HPM=4 decode limits and read-only scountovf
    rd32(12'hB07, v, il);
    checkVal("t6_unimpl_val", v, 64'd0);
    checkVal("t6_unimpl_ill", 64'(il), 64'd1);
    rd32(12'hB06, v, il);
    checkVal("t6_last_ok", 64'(il), 64'd0);
    b32.CSRAdrM = 12'hDA0; b32.CSRWriteValM = 32'hFFFF_FFFF; b32.CSRMWriteM = 1'b1; #1;
    checkVal("t6_ovf_wr_ill", 64'(b32.IllegalAccessM), 64'd1);
    tick();
    b32.CSRMWriteM = 1'b0;
    checkVal("t6_ovf_ro", 64'(ovf32), 64'd0);
    rd32(12'hDA0, v, il);
    checkVal("t6_ovf_rd_ok", 64'(il), 64'd0);

    // Reset in the would-be overflow cycle
    wr64(12'h326, 64'd1);
    wr64(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    ev64 = 32'h1; #1;
    checkVal("t6_pre_rst_pulse", 64'(lcofi64), 64'd1);
    reset = 1'b1; #1;
    checkVal("t6_rst_no_pulse", 64'(lcofi64), 64'd0);
    tick();
    reset = 1'b0; #1;
    checkVal("t6_post_rst_pulse", 64'(lcofi64), 64'd0);
    checkVal("t6_rst_ovf", 64'(ovf64), 64'd0);
    rd64(12'hB03, v, il);
    checkVal("t6_rst_cnt3", v, 64'd0);
    rd64(12'h326, v, il);
    checkVal("t6_rst_evt3", v, 64'd0);
    tick(); ev64 = '0;
    rd64(12'hB03, v, il);
    checkVal("t6_rst_sel0_idle", v, 64'd0);
    rd64(12'hB05, v, il);
    checkVal("t6_rst_cnt5", v, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
